ghash_acc: RTL

GHASH accumulator for the AES-GCM datapath. It takes 128-bit data blocks (AAD, ciphertext, length block) from the cipher/formatting stage and computes Y_i = (Y_{i-1} XOR X_i) · H. Each product goes to the downstream gf128_mul, and the block consumes its reduced result. After the block marked last, it presents the final GHASH value as the tag.

---
 rtl/ghash_acc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ghash_acc.sv
// ghash_acc -- GHASH accumulator for the AES-GCM datapath.
//
// Computes Y_i = (Y_{i-1} ^ X_i) * H by handing each operand pair to an
// external gf128_mul (which must share rst_n) and taking back its reduced
// product. After the block flagged last, the final GHASH value is presented
// on tag_o with a one-cycle tag_valid_o pulse.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr_i                clear accumulator (start of message)
//   h_load_i, h_i        load hash subkey H (only honoured while idle)
//   in_valid_i/ready_o   data block handshake; in_data_i = X_i, in_last_i
//   mul_valid_o, mul_a_o, mul_b_o   operand pulse to the multiplier
//   mul_valid_i, mul_result_i       product returned by the multiplier
//   tag_valid_o, tag_o   final GHASH pulse / accumulator value
//
// Build option: GHASH_PARTIAL_EN adds in_bytes_i [4:0]; bytes at index >=
// in_bytes_i (byte 0 = in_data_i[127:120]) are zeroed before the XOR.
// 0 or >16 is treated as 16.
module ghash_acc (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         h_load_i,
  input  logic [127:0] h_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  input  logic         in_last_i,
`ifdef GHASH_PARTIAL_EN
  input  logic [4:0]   in_bytes_i,
`endif
  output logic         mul_valid_o,
  output logic [127:0] mul_a_o,
  output logic [127:0] mul_b_o,
  input  logic         mul_valid_i,
  input  logic [127:0] mul_result_i,
  output logic         tag_valid_o,
  output logic [127:0] tag_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] acc_q, acc_d;
  logic [127:0] h_q, h_d;
  logic         last_q, last_d;
  logic         mul_valid_q, mul_valid_d;
  logic [127:0] mul_a_q, mul_a_d;
  logic [127:0] mul_b_q, mul_b_d;
  logic         tag_valid_q, tag_valid_d;

  logic [127:0] acc_eff, h_eff, data_eff;

  // Same-cycle clr/h_load take effect before the XOR and the multiply.
  assign acc_eff = clr_i    ? '0  : acc_q;
  assign h_eff   = h_load_i ? h_i : h_q;

`ifdef GHASH_PARTIAL_EN
  logic [4:0]   nbytes;
  logic [127:0] byte_mask;

  always_comb begin
    nbytes    = (in_bytes_i == 5'd0 || in_bytes_i > 5'd16) ? 5'd16 : in_bytes_i;
    byte_mask = '0;
    for (int b = 0; b < 16; b++) begin
      byte_mask[127-8*b -: 8] = (5'(b) < nbytes) ? 8'hFF : 8'h00;
    end
  end

  assign data_eff = in_data_i & byte_mask;
`else
  assign data_eff = in_data_i;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    h_d         = h_q;
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_valid_d = 1'b0;
    tag_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Stray products while idle are ignored.
        if (h_load_i) h_d   = h_i;
        if (clr_i)    acc_d = '0;
        if (in_valid_i) begin
          mul_a_d     = acc_eff ^ data_eff;
          mul_b_d     = h_eff;
          mul_valid_d = 1'b1;
          last_d      = in_last_i;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (clr_i) begin
          acc_d = '0;
          // If the product lands in the same cycle as the clear there is
          // nothing left to drain; going to DRAIN would wait forever.
          state_d = mul_valid_i ? S_IDLE : S_DRAIN;
        end else if (mul_valid_i) begin
          acc_d       = mul_result_i;
          tag_valid_d = last_q;
          state_d     = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (clr_i)       acc_d   = '0;
        if (mul_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      h_q         <= '0;
      last_q      <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      h_q         <= h_d;
      last_q      <= last_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign mul_valid_o = mul_valid_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign tag_valid_o = tag_valid_q;
  assign tag_o       = acc_q;

endmodule
